rptr_empty_lvl: RTL



---
 rtl/rptr_empty_lvl_if.sv | 36 +++
 rtl/rptr_empty_lvl.sv | 117 +++++++++++
 2 files changed

// File: rtl/rptr_empty_lvl_if.sv
// Read-side bus of the dual-clock FIFO: pop request, synchronised write pointer and status.
// rvalid/rload exist only when RPTR_FWFT_EN is defined.
interface rptr_empty_lvl_if #(parameter int ADDRSIZE = 8);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   ae_thresh;
  logic                rerr_clr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;
`ifdef RPTR_FWFT_EN
  logic                rvalid;
  logic                rload;

  modport slave (
    input  rinc, rq2_wptr, ae_thresh, rerr_clr,
    output raddr, rptr, rempty, raempty, rlevel, runderflow, rvalid, rload
  );
  modport master (
    output rinc, rq2_wptr, ae_thresh, rerr_clr,
    input  raddr, rptr, rempty, raempty, rlevel, runderflow, rvalid, rload
  );
`else
  modport slave (
    input  rinc, rq2_wptr, ae_thresh, rerr_clr,
    output raddr, rptr, rempty, raempty, rlevel, runderflow
  );
  modport master (
    output rinc, rq2_wptr, ae_thresh, rerr_clr,
    input  raddr, rptr, rempty, raempty, rlevel, runderflow
  );
`endif
endinterface

// File: rtl/rptr_empty_lvl.sv
// Read pointer, empty/almost-empty flags, fill level and sticky underflow for the async FIFO.
// Optional first-word-fall-through output stage enabled by macro RPTR_FWFT_EN.
module rptr_empty_lvl #(
  parameter int ADDRSIZE = 8
) (
  input  logic rclk,
  input  logic rrst_n,
  rptr_empty_lvl_if.slave bus
);

  logic [ADDRSIZE:0] rbin_reg;
  logic [ADDRSIZE:0] rptr_reg;
  logic [ADDRSIZE:0] rlevel_reg;
  logic              empty_reg;
  logic              aempty_reg;
  logic              uf_reg;

  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] lvl_next;
  logic [ADDRSIZE:0] lvl_total;
  logic              pop;
  logic              uf_set;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
      assign wbin_s[gi] = ^bus.rq2_wptr[ADDRSIZE:gi];
    end
  endgenerate

  assign rbin_next  = rbin_reg + {{ADDRSIZE{1'b0}}, pop};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign lvl_next   = wbin_s - rbin_next;

`ifdef RPTR_FWFT_EN
  typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

  state_t state_reg;
  state_t state_next;
  logic   load;
  logic   valid_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // empty_reg is the memory-side empty; the held word is tracked by the FSM
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_reg) begin
          load       = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (bus.rinc) begin
          if (!empty_reg) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign valid_next = (state_next == VALID);
  assign pop        = load;
  assign uf_set     = bus.rinc & (state_reg != VALID);
  assign lvl_total  = lvl_next + {{ADDRSIZE{1'b0}}, valid_next};
  assign bus.rvalid = (state_reg == VALID);
  assign bus.rload  = load;
  assign bus.rempty = (state_reg != VALID);
`else
  assign pop        = bus.rinc & ~empty_reg;
  assign uf_set     = bus.rinc & empty_reg;
  assign lvl_total  = lvl_next;
  assign bus.rempty = empty_reg;
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_reg   <= '0;
      rptr_reg   <= '0;
      rlevel_reg <= '0;
      empty_reg  <= 1'b1;
      aempty_reg <= 1'b1;
      uf_reg     <= 1'b0;
    end else begin
      rbin_reg   <= rbin_next;
      rptr_reg   <= rgray_next;
      rlevel_reg <= lvl_total;
      empty_reg  <= (rgray_next == bus.rq2_wptr);
      aempty_reg <= (lvl_total <= bus.ae_thresh);
      // a new underflow in the same cycle as a clear must stay visible
      uf_reg     <= uf_set | (uf_reg & ~bus.rerr_clr);
    end
  end

  assign bus.raddr      = rbin_reg[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_reg;
  assign bus.rlevel     = rlevel_reg;
  assign bus.raempty    = aempty_reg;
  assign bus.runderflow = uf_reg;

endmodule
